wb_write_queue: RTL and testbench

//  Write-side initiator for the 32x32 register file: buffers writeback requests from

---
 rtl/wb_write_queue.sv | 142 ++++++++++++++
 tb/tb_wb_write_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback queue in front of the 32x32 register file write port: buffers requests,
// drains the oldest one per unstalled cycle, and exposes queued writes to decode for bypass.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          ctrl_reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_reg,
    input  logic [31:0]   in_data,
    input  logic          wb_stall,
    output logic          ctrl_writeEnable,
    output logic [4:0]    ctrl_writeReg,
    output logic [31:0]   data_writeReg,
    input  logic [4:0]    lookup_regA,
    input  logic [4:0]    lookup_regB,
    output logic          hit_A,
    output logic          hit_B,
    output logic [31:0]   hit_data_A,
    output logic [31:0]   hit_data_B,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic [DEPTH-1:0] valid_r;
    logic [4:0]     reg_r  [DEPTH];
    logic [31:0]    data_r [DEPTH];

    logic           head_valid_s;
    logic           enq_s;
    logic           store_s;
    logic           deq_s;
    logic [AW-1:0]  idx_s;

    // Writes to r0 complete the handshake but occupy no slot.
    assign in_ready     = (count_r != FULL_COUNT);
    assign head_valid_s = (count_r != {(AW + 1){1'b0}});
    assign enq_s        = in_valid && in_ready;
    assign store_s      = enq_s && (in_reg != 5'd0);
    assign deq_s        = head_valid_s && !wb_stall;
    assign count        = count_r;

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
            valid_r  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                reg_r[i]  <= 5'd0;
                data_r[i] <= 32'd0;
            end
        end else begin
            if (store_s) begin
                reg_r[wr_ptr_r]   <= in_reg;
                data_r[wr_ptr_r]  <= in_data;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + AW'(1);
            end
            if (deq_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + AW'(1);
            end
            case ({store_s, deq_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Regfile write port driven straight from the head entry.
    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        if (head_valid_s) begin
            ctrl_writeEnable = !wb_stall;
            ctrl_writeReg    = reg_r[rd_ptr_r];
            data_writeReg    = data_r[rd_ptr_r];
        end else begin
            ctrl_writeEnable = 1'b0;
        end
    end

    // Bypass lookup: walk oldest to youngest so the youngest match overrides.
    always_comb begin
        hit_A      = 1'b0;
        hit_B      = 1'b0;
        hit_data_A = 32'd0;
        hit_data_B = 32'd0;
        idx_s      = {AW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = rd_ptr_r + AW'(i);
            if (valid_r[idx_s] && (lookup_regA != 5'd0) && (reg_r[idx_s] == lookup_regA)) begin
                hit_A      = 1'b1;
                hit_data_A = data_r[idx_s];
            end else begin
                hit_A      = hit_A;
            end
            if (valid_r[idx_s] && (lookup_regB != 5'd0) && (reg_r[idx_s] == lookup_regB)) begin
                hit_B      = 1'b1;
                hit_data_B = data_r[idx_s];
            end else begin
                hit_B      = hit_B;
            end
        end
    end

    wb_write_queue_checker #(.DEPTH(DEPTH), .AW(AW)) u_checker (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .count        (count_r)
    );

endmodule

// Simulation-only occupancy check for the queue.
module wb_write_queue_checker #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic        clock,
    input logic        ctrl_reset_n,
    input logic [AW:0] count
);

    // Occupancy must never exceed the number of slots.
    always_ff @(posedge clock) begin
        if (ctrl_reset_n) begin
            assert (count <= (AW + 1)'(DEPTH));
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: accepted writes are queued in the bench and
// popped against the regfile write port; lookups are checked against the same queue.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clock = 1'b0;
    logic          ctrl_reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_reg;
    logic [31:0]   in_data;
    logic          wb_stall;
    logic          ctrl_writeEnable;
    logic [4:0]    ctrl_writeReg;
    logic [31:0]   data_writeReg;
    logic [4:0]    lookup_regA;
    logic [4:0]    lookup_regB;
    logic          hit_A;
    logic          hit_B;
    logic [31:0]   hit_data_A;
    logic [31:0]   hit_data_B;
    logic [AW:0]   count;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_reg           (in_reg),
        .in_data          (in_data),
        .wb_stall         (wb_stall),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .lookup_regA      (lookup_regA),
        .lookup_regB      (lookup_regB),
        .hit_A            (hit_A),
        .hit_B            (hit_B),
        .hit_data_A       (hit_data_A),
        .hit_data_B       (hit_data_B),
        .count            (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Youngest queued write to address a, searched from the tail of the scoreboard.
    task automatic model_lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        if (a != 5'd0) begin
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].r == a) begin
                    h = 1'b1;
                    d = sb_q[i].d;
                    break;
                end
            end
        end
    endtask

    // One clock: drive at negedge, check settled outputs, update model, wait for posedge.
    task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d,
                        input logic st, input logic [4:0] la, input logic [4:0] lb);
        logic        exp_we;
        logic        accepted;
        logic        eh;
        logic [31:0] ed;
        ent_t        e;
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        in_valid     = v;
        in_reg       = r;
        in_data      = d;
        wb_stall     = st;
        lookup_regA  = la;
        lookup_regB  = lb;
        #1;
        check("in_ready", in_ready, sb_q.size() < DEPTH);
        check("count", count, sb_q.size());
        exp_we = (sb_q.size() != 0) && !st;
        check("write_en", ctrl_writeEnable, exp_we);
        if (sb_q.size() != 0) begin
            check("write_reg", ctrl_writeReg, sb_q[0].r);
            check("write_data", data_writeReg, sb_q[0].d);
        end else begin
            check("write_reg_empty", ctrl_writeReg, 32'd0);
            check("write_data_empty", data_writeReg, 32'd0);
        end
        model_lookup(la, eh, ed);
        check("hit_A", hit_A, eh);
        check("hit_data_A", hit_data_A, ed);
        model_lookup(lb, eh, ed);
        check("hit_B", hit_B, eh);
        check("hit_data_B", hit_data_B, ed);
        accepted = v && (sb_q.size() < DEPTH);
        if (exp_we) begin
            void'(sb_q.pop_front());
        end
        if (accepted && (r != 5'd0)) begin
            e.r = r;
            e.d = d;
            sb_q.push_back(e);
        end
        @(posedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        ctrl_reset_n = 1'b0;
        in_valid     = 1'b1;
        in_reg       = 5'd5;
        in_data      = 32'h5555_5555;
        wb_stall     = 1'b0;
        lookup_regA  = 5'd5;
        lookup_regB  = 5'd0;
        @(posedge clock);
        sb_q.delete();
        #1;
        check("rst_count", count, 32'd0);
        check("rst_write_en", ctrl_writeEnable, 32'd0);
        check("rst_in_ready", in_ready, 32'd1);
        check("rst_hit_A", hit_A, 32'd0);
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        in_valid     = 1'b0;
        in_reg       = 5'd0;
        in_data      = 32'd0;
        wb_stall     = 1'b0;
        lookup_regA  = 5'd0;
        lookup_regB  = 5'd0;
        apply_reset();

        // Reset discards queued writes.
        for (int i = 0; i < 3; i++) step(1'b1, 5'd5, 32'h100 + 32'(i), 1'b1, 5'd5, 5'd0);
        apply_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);

        // Single write commits one edge after acceptance.
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd5, 5'd0);
        #1;
        check("single_we", ctrl_writeEnable, 32'd1);
        check("single_reg", ctrl_writeReg, 32'd5);
        check("single_data", data_writeReg, 32'hDEAD_BEEF);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
        #1;
        check("single_drained", count, 32'd0);

        // Fill under stall, hold a fifth request, then release.
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(i * 17), 1'b1, 5'(i), 5'd0);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd2, 5'd4);
        #1;
        check("fill_count", count, 32'd4);
        check("fill_ready", in_ready, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd1);
        for (int i = 0; i < 2; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd0);

        // Youngest matching entry wins the bypass.
        step(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 5'd8);
        step(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 5'd8);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd8);
        #1;
        check("bypass_hit_A", hit_A, 32'd1);
        check("bypass_data_A", hit_data_A, 32'hB);
        check("bypass_hit_B", hit_B, 32'd0);
        check("bypass_data_B", hit_data_B, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);

        // r0 writes handshake but are dropped.
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0);
        #1;
        check("r0_count", count, 32'd0);
        check("r0_no_write", ctrl_writeEnable, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

        // Random bursts with random stalls exercise pointer wrap.
        for (int b = 0; b < 10; b++) begin
            int len;
            len = $urandom_range(3, 12);
            for (int c = 0; c < len; c++) begin
                step(($urandom % 4) != 0, 5'($urandom_range(0, 7)), $urandom,
                     ($urandom % 3) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd6);
        #1;
        check("final_empty", count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
